// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared uart defaults, baud FSM encoding and period helper
package uart_pkg;

  localparam logic [15:0] DEFAULT_PERIOD    = 16'd20;
  localparam logic [3:0]  DEFAULT_UP_TIME   = 4'd10;
  localparam logic [3:0]  DEFAULT_DOWN_TIME = 4'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } baud_state_e;

  typedef struct packed {
    logic [15:0] period;
    logic [3:0]  up;
    logic [3:0]  down;
  } acq_cfg_t;

  // Period of 0 behaves as 1; the round-up period adds one clock without wrapping.
  function automatic logic [16:0] acq_len(input logic [15:0] period, input logic round_up);
    logic [16:0] base;
    base = (period == 16'd0) ? 17'd1 : {1'b0, period};
    return base + {16'd0, round_up};
  endfunction

endpackage

// File: rtl/acq_period_cnt.sv
// rtl/acq_period_cnt.sv - clearable terminal-count counter with a done strobe
module acq_period_cnt #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [CNT_W:0] term_i,
  output logic           done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = en_i && ({1'b0, cnt_q} == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acq_baud_gen.sv
// rtl/acq_baud_gen.sv - acquisition/bit timing generator with round-up/round-down periods
module acq_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_Enable_i,
  input  logic        p_Sync_i,
  input  logic [15:0] BaudRateGen_i,
  input  logic [7:0]  BitCompensation_i,
  output logic        p_AcqSig_o,
  output logic        p_BitSig_o,
  output logic [3:0]  AcqIndex_o,
  output logic        p_CfgErr_o
);

  baud_state_e state_q, state_d;
  acq_cfg_t    cfg_q, cfg_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  idxo_q, idxo_d;
  logic        acq_q, acq_d;
  logic        bit_q, bit_d;

  acq_cfg_t    live_cfg;
  logic        live_zero;
  logic [4:0]  last_idx;
  logic [16:0] len;
  logic [16:0] len_m1;
  logic [CNT_W:0] term;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_done;

  assign live_cfg  = '{period: BaudRateGen_i, up: BitCompensation_i[7:4], down: BitCompensation_i[3:0]};
  assign live_zero = (BitCompensation_i == 8'd0);
  assign last_idx  = {1'b0, cfg_q.up} + {1'b0, cfg_q.down} - 5'd1;
  assign len       = acq_len(cfg_q.period, idx_q < {1'b0, cfg_q.up});
  assign len_m1    = len - 17'd1;
  assign term      = (CNT_W+1)'(len_m1);

  acq_period_cnt #(.CNT_W(CNT_W)) u_period_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (term),
    .done_o (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    idxo_d  = idx_q[3:0];
    acq_d   = 1'b0;
    bit_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        idxo_d  = '0;
        cnt_clr = 1'b1;
        if (p_Enable_i && !live_zero) begin
          state_d = ST_RUN;
          cfg_d   = live_cfg;
        end
      end
      ST_RUN: begin
        if (!p_Enable_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          idxo_d  = '0;
          cnt_clr = 1'b1;
        end else if (p_Sync_i) begin
          // Restart wins over any pulse that would have landed on this edge.
          cfg_d   = live_cfg;
          idx_d   = '0;
          idxo_d  = '0;
          cnt_clr = 1'b1;
          if (live_zero) state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            acq_d = 1'b1;
            if (idx_q == last_idx) begin
              bit_d = 1'b1;
              idx_d = '0;
              cfg_d = live_cfg;
              if (live_zero) state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '{period: DEFAULT_PERIOD, up: DEFAULT_UP_TIME, down: DEFAULT_DOWN_TIME};
      idx_q   <= '0;
      idxo_q  <= '0;
      acq_q   <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      idxo_q  <= idxo_d;
      acq_q   <= acq_d;
      bit_q   <= bit_d;
    end
  end

  // AcqIndex_o lags the period counter by one so a pulse carries the index it closes.
  assign p_AcqSig_o = acq_q;
  assign p_BitSig_o = bit_q;
  assign AcqIndex_o = idxo_q;
  assign p_CfgErr_o = p_Enable_i && live_zero;

endmodule

// File: tb/tb_acq_baud_gen.sv
// tb/tb_acq_baud_gen.sv - randomized and directed bench against a pulse-schedule model
module tb_acq_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic [15:0] p;
  logic [7:0]  bc;
  logic        acq_o;
  logic        bit_o;
  logic [3:0]  idx_o;
  logic        cfgerr_o;

  acq_baud_gen #(.CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .p_Enable_i        (en),
    .p_Sync_i          (sync),
    .BaudRateGen_i     (p),
    .BitCompensation_i (bc),
    .p_AcqSig_o        (acq_o),
    .p_BitSig_o        (bit_o),
    .AcqIndex_o        (idx_o),
    .p_CfgErr_o        (cfgerr_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit m_run = 0;
  int m_p, m_u, m_d, m_idx, m_next;
  int exp_bit_gap = 0;
  int last_bit_t = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Length of period k in a bit: the first U periods are one clock longer.
  function automatic int mlen(input int pp, input int uu, input int k);
    return ((pp == 0) ? 1 : pp) + ((k < uu) ? 1 : 0);
  endfunction

  task automatic capture();
    m_p = p;
    m_u = bc[7:4];
    m_d = bc[3:0];
    m_idx = 0;
    m_next = cyc + mlen(m_p, m_u, 0);
    if (m_u + m_d == 0) m_run = 0;
  endtask

  task automatic tick();
    int ea, eb, ei;
    bit ci;
    @(posedge clk);
    cyc++;
    ea = 0; eb = 0; ei = 0; ci = 0;
    if (rst) begin
      m_run = 0; ci = 1;
    end else if (!m_run) begin
      ci = 1;
      if (en && bc != 8'd0) begin
        m_run = 1;
        capture();
      end
    end else if (!en) begin
      m_run = 0; ci = 1;
    end else if (sync) begin
      capture(); ci = 1;
    end else if (cyc == m_next) begin
      ea = 1; ei = m_idx; ci = 1;
      if (m_idx == m_u + m_d - 1) begin
        eb = 1;
        capture();
      end else begin
        m_idx++;
        m_next = cyc + mlen(m_p, m_u, m_idx);
      end
    end
    @(negedge clk);
    chk("pulses", {30'd0, acq_o, bit_o}, {30'd0, ea[0], eb[0]});
    if (ci) chk("acq_index", {28'd0, idx_o}, ei & 15);
    chk("cfg_err", {31'd0, cfgerr_o}, {31'd0, (en && bc == 8'd0)});
    if (bit_o === 1'b1) begin
      if (exp_bit_gap != 0 && last_bit_t >= 0) chk("bit_gap", cyc - last_bit_t, exp_bit_gap);
      last_bit_t = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_gap(input int g);
    exp_bit_gap = g;
    last_bit_t = -1;
  endtask

  initial begin
    int cap;
    bit found;
    rst = 1'b1; en = 1'b0; sync = 1'b0; p = 16'd20; bc = 8'hA5;
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // Default-style timing: 10x21 + 5x20 clocks per bit.
    expect_gap(310);
    en = 1'b1;
    ticks(700);
    expect_gap(0);

    // Enable drop mid-bit, then restart latency.
    en = 1'b0;
    ticks(3);
    en = 1'b1;
    tick();
    cap = cyc;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (acq_o === 1'b1) begin
        found = 1;
        chk("restart_latency", cyc - cap, 21);
      end
    end
    if (!found) chk("restart_timeout", 0, 1);
    ticks(40);

    // Reset mid-bit aborts silently, enable still high restarts.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(60);

    // P=3, U=0, D=4.
    en = 1'b0;
    tick();
    p = 16'd3; bc = 8'h04; en = 1'b1;
    expect_gap(12);
    ticks(60);

    // Mid-bit config change takes effect from the next bit.
    en = 1'b0;
    tick();
    p = 16'd20; bc = 8'hA5; en = 1'b1;
    expect_gap(82);
    ticks(150);
    bc = 8'h22;
    ticks(450);
    expect_gap(0);

    // Sync landing on a scheduled pulse edge.
    bc = 8'hA5;
    for (int i = 0; i < 400 && m_next != cyc + 1; i++) tick();
    if (m_next != cyc + 1) chk("sync_wait_timeout", 0, 1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    ticks(60);

    // Zero compensation at a bit boundary stops the generator.
    bc = 8'h00;
    ticks(400);
    // Zero compensation from idle never starts.
    en = 1'b0;
    tick();
    en = 1'b1;
    ticks(20);

    // P=0, U=0, D=1: a bit every clock.
    p = 16'd0; bc = 8'h01;
    tick();
    expect_gap(1);
    ticks(20);
    expect_gap(0);

    // Random segments with syncs, enable drops and config changes.
    for (int s = 0; s < 20; s++) begin
      p = 16'($urandom_range(0, 30));
      bc = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      en = 1'b1;
      for (int i = 0; i < 80; i++) begin
        sync = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 59) == 0) en = ~en;
        if ($urandom_range(0, 49) == 0) bc = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        if ($urandom_range(0, 49) == 0) p = 16'($urandom_range(0, 30));
        tick();
      end
      sync = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
